// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder_pkg
// Brief   : Memory request/response bundle types, opcode enums and helpers.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        M_XRD       = 2'd0,
        M_XWR       = 2'd1,
        M_X         = 2'd2,
        M_FLUSH_ALL = 2'd3
    } memory_write_signal_e;

    typedef enum logic [2:0] {
        MT_B    = 3'd0,
        MT_BU   = 3'd1,
        MT_H    = 3'd2,
        MT_HU   = 3'd3,
        MT_W    = 3'd4,
        MT_WU   = 3'd5,
        MT_X    = 3'd6,
        MT_RSVD = 3'd7
    } memory_mask_type_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fcn;
        logic [2:0]  typ;
    } memory_req_t;

    typedef struct packed {
        memory_req_t req;
        logic        req_valid;
    } memory_in_t;

    typedef struct packed {
        logic [31:0] data;
    } memory_res_t;

    typedef struct packed {
        memory_res_t res;
        logic        req_ready;
        logic        res_valid;
    } memory_out_t;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    function automatic logic misaligned(input memory_mask_type_e typ, input logic [1:0] addr);
        logic result;
        result = 1'b0;
        case (typ)
            MT_H, MT_HU: result = addr[0];
            MT_W, MT_WU: result = (addr != 2'b00);
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_align
// Brief   : Byte-lane steering for stores and sign/zero extension for loads.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  i_typ,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    memory_mask_type_e w_typ;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_typ  = memory_mask_type_e'(i_typ);
    assign w_byte = i_rword[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_rword[31:16] : i_rword[15:0];

    // Store data is replicated across lanes so the enable mask alone picks the target.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'd0;
        case (w_typ)
            MT_B, MT_BU: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (w_typ == MT_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            end
            MT_H, MT_HU: begin
                o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (w_typ == MT_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            end
            MT_W, MT_WU: begin
                o_be    = 4'b1111;
                o_rdata = i_rword;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Scratchpad-backed data-memory responder with fixed response latency.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [69:0] mem_in,
    output logic [33:0] mem_out,
    output logic        err
);
    localparam int         c_aw       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_cnt_load = 2'(LATENCY >= 2 ? LATENCY - 2 : 0);

    memory_in_t           w_in;
    memory_out_t          w_out;
    memory_write_signal_e w_fcn;
    memory_mask_type_e    w_typ;
    logic [c_aw-1:0]      w_idx;
    logic [31:0]          w_rword;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_rdata;
    logic                 w_active;
    logic                 w_misaligned;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_res_valid;
    logic                 w_unused_ok;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_nxt;
    logic [31:0]          r_res_data;
    logic                 r_res_err;
    logic [31:0]          r_mem [DEPTH_WORDS];

    assign w_in         = mem_in;
    assign w_fcn        = memory_write_signal_e'(w_in.req.fcn);
    assign w_typ        = memory_mask_type_e'(w_in.req.typ);
    assign w_idx        = w_in.req.addr[2 +: c_aw];
    assign w_rword      = r_mem[w_idx];
    assign w_unused_ok  = ^w_in.req.addr;
    assign w_active     = ((w_fcn == M_XRD) || (w_fcn == M_XWR)) &&
                          (w_typ != MT_X) && (w_typ != MT_RSVD);
    assign w_misaligned = misaligned(w_typ, w_in.req.addr[1:0]);
    // Ready is masked by reset directly so it drops the moment reset asserts.
    assign w_req_ready  = reset_n && ((r_state == c_st_idle) || (r_state == c_st_resp));
    assign w_accept     = w_in.req_valid && w_req_ready;
    assign w_res_valid  = (r_state == c_st_resp);

    mem_lane_align u_lane_align (
        .i_typ   (w_in.req.typ),
        .i_addr  (w_in.req.addr[1:0]),
        .i_wdata (w_in.req.data),
        .i_rword (w_rword),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_accept && w_active && !w_misaligned && (w_fcn == M_XWR)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= 2'd0;
            r_res_data <= 32'd0;
            r_res_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_res_err  <= w_active && w_misaligned;
                r_res_data <= (w_active && !w_misaligned && (w_fcn == M_XRD)) ? w_rdata : 32'd0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle, c_st_resp: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = c_st_resp;
                    end else begin
                        w_state_nxt = c_st_wait;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wait: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = c_st_resp;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_out.res.data  = w_res_valid ? r_res_data : 32'd0;
    assign w_out.req_ready = w_req_ready;
    assign w_out.res_valid = w_res_valid;
    assign mem_out         = w_out;
    assign err             = w_res_valid && r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed vector bench for dmem_responder at LATENCY 1 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [1:0] F_RD = 2'd0, F_WR = 2'd1, F_X = 2'd2, F_FL = 2'd3;
    localparam logic [2:0] T_B = 3'd0, T_BU = 3'd1, T_H = 3'd2, T_HU = 3'd3;
    localparam logic [2:0] T_W = 3'd4, T_X = 3'd6, T_7 = 3'd7;

    logic        clk;
    logic        reset1_n, reset3_n;
    logic [69:0] in1, in3;
    logic [33:0] out1, out3;
    logic        err1, err3;
    int          n_total;
    int          n_pass;

    typedef struct {
        logic [1:0]  fcn;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset1_n), .mem_in(in1), .mem_out(out1), .err(err1));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset3_n), .mem_in(in3), .mem_out(out3), .err(err3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] pk(input logic [1:0] f, input logic [2:0] t,
                                       input logic [31:0] a, input logic [31:0] d, input logic v);
        return {a, d, f, t, v};
    endfunction

    // Observed tuple: {res_valid, req_ready, err, res.data}
    function automatic logic [39:0] exp_st(input logic v, input logic r, input logic e, input logic [31:0] d);
        return {5'd0, v, r, e, d};
    endfunction

    function automatic logic [39:0] st1();
        return {5'd0, out1[0], out1[1], err1, out1[33:2]};
    endfunction

    function automatic logic [39:0] st3();
        return {5'd0, out3[0], out3[1], err3, out3[33:2]};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {valid,ready,err,data}=%h expected %h", name, act, exp);
    endtask

    task automatic add(input logic [1:0] f, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e, input logic er);
        vec_t v;
        v.fcn = f; v.typ = t; v.addr = a; v.wdata = d; v.exp_data = e; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic lat3(input string name, input logic [1:0] f, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] e, input logic er);
        in3 = pk(f, t, a, d, 1'b1);
        @(posedge clk); #1;
        in3 = pk(f, t, a, d, 1'b0);
        check({name, " c1"}, st3(), exp_st(1'b0, 1'b0, 1'b0, 32'd0));
        @(posedge clk); #1;
        check({name, " c2"}, st3(), exp_st(1'b0, 1'b0, 1'b0, 32'd0));
        @(posedge clk); #1;
        check({name, " c3"}, st3(), exp_st(1'b1, 1'b1, er, e));
        @(posedge clk); #1;
        check({name, " c4"}, st3(), exp_st(1'b0, 1'b1, 1'b0, 32'd0));
    endtask

    task automatic reset_mid(input string name, input logic [1:0] f, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] d);
        logic seen;
        in3 = pk(f, t, a, d, 1'b1);
        @(posedge clk); #1;
        in3 = pk(f, t, a, d, 1'b0);
        reset3_n = 1'b0;
        #1;
        check({name, " in_reset"}, st3(), 40'd0);
        @(posedge clk); #1;
        reset3_n = 1'b1;
        #1;
        check({name, " released"}, st3(), exp_st(1'b0, 1'b1, 1'b0, 32'd0));
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | out3[0];
        end
        check({name, " no_resp"}, {39'd0, seen}, 40'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset1_n = 1'b0;
        reset3_n = 1'b0;
        in1      = 70'd0;
        in3      = 70'd0;

        add(F_WR, T_W,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
        add(F_RD, T_W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
        add(F_WR, T_W,  32'h20,   32'h0,        32'h0,        1'b0);
        add(F_WR, T_B,  32'h21,   32'h000000F0, 32'h0,        1'b0);
        add(F_RD, T_W,  32'h20,   32'h0,        32'h0000F000, 1'b0);
        add(F_RD, T_B,  32'h21,   32'h0,        32'hFFFFFFF0, 1'b0);
        add(F_RD, T_BU, 32'h21,   32'h0,        32'h000000F0, 1'b0);
        add(F_WR, T_W,  32'h30,   32'h11112222, 32'h0,        1'b0);
        add(F_WR, T_H,  32'h32,   32'h00008001, 32'h0,        1'b0);
        add(F_RD, T_H,  32'h32,   32'h0,        32'hFFFF8001, 1'b0);
        add(F_RD, T_HU, 32'h32,   32'h0,        32'h00008001, 1'b0);
        add(F_RD, T_W,  32'h30,   32'h0,        32'h80012222, 1'b0);
        add(F_WR, T_W,  32'h40,   32'hCAFEF00D, 32'h0,        1'b0);
        add(F_WR, T_W,  32'h41,   32'h12345678, 32'h0,        1'b1);
        add(F_RD, T_W,  32'h40,   32'h0,        32'hCAFEF00D, 1'b0);
        add(F_RD, T_H,  32'h43,   32'h0,        32'h0,        1'b1);
        add(F_RD, T_B,  32'h43,   32'h0,        32'hFFFFFFCA, 1'b0);
        add(F_X,  T_W,  32'h40,   32'h0,        32'h0,        1'b0);
        add(F_RD, T_X,  32'h40,   32'h0,        32'h0,        1'b0);
        add(F_FL, T_W,  32'h40,   32'h0,        32'h0,        1'b0);
        add(F_RD, T_W,  32'h40,   32'h0,        32'hCAFEF00D, 1'b0);
        add(F_RD, T_W,  32'h1010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(F_WR, T_H,  32'h31,   32'h0000FFFF, 32'h0,        1'b1);
        add(F_RD, T_W,  32'h30,   32'h0,        32'h80012222, 1'b0);
        add(F_RD, T_HU, 32'h30,   32'h0,        32'h00002222, 1'b0);
        add(F_WR, T_B,  32'h13,   32'h00000055, 32'h0,        1'b0);
        add(F_RD, T_W,  32'h10,   32'h0,        32'h55ADBEEF, 1'b0);
        add(F_WR, T_7,  32'h10,   32'h0,        32'h0,        1'b0);
        add(F_RD, T_W,  32'h10,   32'h0,        32'h55ADBEEF, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("reset1 outputs", st1(), 40'd0);
        check("reset3 outputs", st3(), 40'd0);
        reset1_n = 1'b1;
        reset3_n = 1'b1;
        #1;
        check("reset1 release ready", st1(), exp_st(1'b0, 1'b1, 1'b0, 32'd0));

        // Back-to-back stream: each response must appear the cycle after acceptance.
        for (int i = 0; i < vecs.size(); i++) begin
            in1 = pk(vecs[i].fcn, vecs[i].typ, vecs[i].addr, vecs[i].wdata, 1'b1);
            @(posedge clk); #1;
            check($sformatf("lat1 vec%0d", i), st1(),
                  exp_st(1'b1, 1'b1, vecs[i].exp_err, vecs[i].exp_data));
        end
        in1 = 70'd0;
        @(posedge clk); #1;
        check("lat1 idle after stream", st1(), exp_st(1'b0, 1'b1, 1'b0, 32'd0));

        lat3("lat3 SW alias 0x1000", F_WR, T_W, 32'h1000, 32'hA5A5A5A5, 32'h0, 1'b0);
        lat3("lat3 LW 0x0",          F_RD, T_W, 32'h0,    32'h0, 32'hA5A5A5A5, 1'b0);
        lat3("lat3 LH 0x2",          F_RD, T_H, 32'h2,    32'h0, 32'hFFFFA5A5, 1'b0);
        lat3("lat3 SW misaligned",   F_WR, T_W, 32'h6,    32'h12345678, 32'h0, 1'b1);
        reset_mid("rst during store", F_WR, T_W, 32'h8, 32'h13579BDF);
        lat3("lat3 LW committed store", F_RD, T_W, 32'h8, 32'h0, 32'h13579BDF, 1'b0);
        reset_mid("rst during load", F_RD, T_W, 32'h0, 32'h0);
        lat3("lat3 LW after reset",  F_RD, T_W, 32'h0,    32'h0, 32'hA5A5A5A5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory request/response interface: consumes MemoryIn, produces MemoryOut.
- Backs the interface with an on-chip word-addressed scratchpad. Handles byte/half/word stores and sign/zero-extended loads.
- Returns each response after a fixed, parameterised latency.
- Sits opposite the core's memory stage; used as dmem in simulation and FPGA builds.

Parameters:
DEPTH_WORDS  1024  scratchpad size in 32-bit words, power of two, >= 2
LATENCY      1     cycles from request acceptance to response, 1..4

Ports:
clk             input   1   single clock, rising edge
reset_n         input   1   asynchronous active-low reset
mem_in          input   70  Bundle::MemoryIn: req.addr[31:0], req.data[31:0], req.fcn[1:0], req.typ[2:0], req_valid
mem_out         output  34  Bundle::MemoryOut: res.data[31:0], req_ready, res_valid
err             output  1   one-cycle pulse alongside res_valid when the request was misaligned

Behaviour:
- Reset: asynchronous assert, synchronous-safe deassert.
  - While reset_n=0: state=IDLE, req_ready=0, res_valid=0, res.data=0, err=0, latency counter=0.
  - First cycle after deassert: req_ready=1.
  - Array contents are not reset.
- Accept: a request is accepted at a rising edge where req_valid && req_ready. Only one request is outstanding at a time.
- FSM:
  - IDLE: req_ready=1. On accept, go to RESP if LATENCY=1, otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. Decrement cnt each cycle; when cnt=0, go to RESP.
  - RESP: res_valid=1 for exactly one cycle and req_ready=1. On accept, go to RESP or WAIT as from IDLE; otherwise go to IDLE.
  - With LATENCY=1 this gives back-to-back throughput of 1 request/cycle.
- Timing: accepted at edge N → res_valid high during cycle N+LATENCY.
- No backpressure on responses: the requester must take res_valid when it is asserted. res.data and err are 0 whenever res_valid=0.
- Addressing: word index = addr[2 +: log2(DEPTH_WORDS)]. Upper bits are ignored, so addresses wrap modulo the array size. Byte lane = addr[1:0].
- fcn encoding: M_XRD=0, M_XWR=1, M_X=2, M_FLUSH_ALL=3. typ encoding: MT_B=0, MT_BU=1, MT_H=2, MT_HU=3, MT_W=4, MT_WU=5, MT_X=6.
- Store (M_XWR):
  - Commits at the acceptance edge.
  - MT_B/BU: write req.data[7:0] into lane addr[1:0].
  - MT_H/HU: write req.data[15:0] into lanes {addr[1],0},{addr[1],1}.
  - MT_W/WU: write all four lanes.
  - Response data = 0.
- Load (M_XRD):
  - The array word is read at the acceptance edge, so a load accepted in the cycle after a store sees the stored data. The extracted value is held in the response pipeline.
  - MT_B sign-extends the byte, MT_BU zero-extends it. MT_H sign-extends the half, MT_HU zero-extends it. MT_W/WU return the full word.
- Misaligned requests:
  - Condition: H/HU with addr[0]=1, or W/WU with addr[1:0]!=0.
  - Stores are suppressed and loads return 0. The request is still acknowledged normally, with err=1 in the response cycle.
- No-op requests: fcn M_X or M_FLUSH_ALL, or typ MT_X/7. Acknowledged with data 0, err 0, and no array change.
- Reset asserted mid-operation: an in-flight response is dropped (res_valid never rises). A store already committed stays in the array.

Decomposition:
- Add to Bundle:
  - typed aliases for the fcn/typ codes as enums (MemoryWriteSignal, MemoryMaskType already exist; cast req fields to them);
  - a localparam-free function `misaligned(typ, addr)`.
- One combinational sub-module, mem_lane_align:
  - inputs: typ, addr[1:0], wdata, rword;
  - outputs: 4-bit byte write-enable, lane-shifted write data, extended load data.
- FSM, counter and array stay in dmem_responder.

Test Plan:
- LATENCY=1: SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 accepted on the next edge → res_valid in the following cycle with 0xDEADBEEF. req_ready stays 1 throughout; two res_valid pulses on consecutive cycles.
- Word preset to 0x00000000; SB addr=0x21 data=0x000000F0 → LW 0x20 returns 0x0000F000. LB 0x21 returns 0xFFFFFFF0. LBU 0x21 returns 0x000000F0.
- SH addr=0x32 data=0x8001 → LH 0x32 returns 0xFFFF8001. LHU 0x32 returns 0x00008001. LW 0x30 has upper half 0x8001.
- Misaligned: SW 0x41 data=0x12345678 → acknowledged with err=1, and LW 0x40 returns the prior value unchanged. LH 0x43 → data 0 with err=1.
- LATENCY=3: accept at edge 0 → req_ready=0 in cycles 1–2, res_valid=1 in cycle 3 only. With DEPTH_WORDS=1024, addr 0x1000 aliases to 0x0.
- reset_n low in cycle 1 of a LATENCY=3 load → res_valid never asserts. After release, req_ready=1 and a new load completes normally.
